mem_arbiter: RTL
================

# mem_arbiter

Two-into-one arbiter that shares a single memory port between the core's instruction-fetch (imem) and load/store (dmem) requesters. It sits between the core and the memory model and uses the same valid/ready command bus with separate read and write channels on every side. It allows one outstanding transaction at a time, alternates grants round-robin on conflict, and steers read data and write responses back to the requester that owns the transaction.

## Interface
- p_ADDR_BITS, 32, address width
- p_DATA_BITS, 32, data width
- p_STRB_BITS, p_DATA_BITS/8, write-strobe width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- imem_addr/imem_cmd/imem_size/imem_valid  in  p_ADDR_BITS/1/2/1  fetch request; imem_cmd is ignored and always treated as read
- imem_ready  out  1  fetch request accepted
- imem_r_ready  in  1  fetch requester accepts read data
- imem_r_valid/imem_r_data/imem_r_resp  out  1/p_DATA_BITS/1  fetch read response
- dmem_addr/dmem_cmd/dmem_size/dmem_valid  in  p_ADDR_BITS/1/2/1  load/store request; cmd 0 = read, 1 = write
- dmem_ready  out  1  load/store request accepted
- dmem_r_ready  in  1; dmem_r_valid/dmem_r_data/dmem_r_resp  out  1/p_DATA_BITS/1  load response
- dmem_w_valid/dmem_w_strb/dmem_w_data  in  1/p_STRB_BITS/p_DATA_BITS  store data
- dmem_w_ready/dmem_w_resp  out  1/1  store data accepted / store response
- mem_addr/mem_cmd/mem_size/mem_valid  out  p_ADDR_BITS/1/2/1  downstream request; mem_ready  in  1
- mem_r_ready  out  1; mem_r_valid/mem_r_data/mem_r_resp  in  1/p_DATA_BITS/1
- mem_w_valid/mem_w_strb/mem_w_data  out  1/p_STRB_BITS/p_DATA_BITS; mem_w_ready/mem_w_resp  in  1/1

## Operation
- FSM states: IDLE, RD, WR. Owner register: IMEM or DMEM.
- IDLE:
  - The round-robin grant picks one valid requester.
  - If both are valid, the requester that was not granted last wins.
  - The last-grant register resets to IMEM, so DMEM wins the first conflict.
  - The granted requester's addr/cmd/size/valid drive mem_* combinationally; imem drives mem_cmd = 0.
  - With no grant, mem_valid, mem_addr, mem_cmd and mem_size are 0.
  - Only the granted port sees its ready (= mem_ready). The other port's ready is 0.
- Acceptance happens when mem_valid && mem_ready:
  - Latch the owner and update the last-grant register.
  - Go to RD for cmd 0, or to WR for cmd 1.
- RD:
  - Downstream mem_valid = 0.
  - mem_r_ready = the owner's r_ready.
  - The owner's r_valid/r_data/r_resp mirror mem_r_*. The non-owner's r_valid = 0 and its r_data = 0.
  - On mem_r_valid && mem_r_ready, return to IDLE.
- WR (owner is always DMEM):
  - mem_w_valid/strb/data mirror dmem_w_*.
  - dmem_w_ready = mem_w_ready and dmem_w_resp = mem_w_resp.
  - On the w handshake, return to IDLE.
- Outside WR: mem_w_valid = 0, mem_w_strb = 0, mem_w_data = 0, dmem_w_ready = 0.
- Each requester must hold its request stable until ready; the arbiter does not buffer requests.

## Timing
- Reset (rst low, asynchronous):
  - State goes to IDLE, last grant to IMEM.
  - Any in-flight transaction is dropped without a response.
  - With requester inputs idle, every output is 0.
- Request path is combinational. Acceptance takes the same cycle as valid && grant && mem_ready.
- Response path is combinational pass-through; the arbiter adds 0 cycles of latency.
- Exactly one IDLE cycle separates back-to-back transactions, so peak throughput is one transaction per 2 + N cycles, where N is downstream response latency in cycles.
- Simultaneous valid in IDLE: strict alternation. A continuously requesting port waits at most one transaction.
- mem_r_valid in IDLE or WR is ignored: not forwarded, and mem_r_ready = 0.
- A w handshake may coincide with the WR entry edge + 1 at the earliest. Store data presented before acceptance is not consumed.
- The grant holds for the whole transaction. A requester dropping valid after acceptance has no effect.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE/RD/WR)
  - owner enum (IMEM/DMEM)
  - CMD_RD = 1'b0, CMD_WR = 1'b1
- Sub-module mem_arb_rr: 2-way round-robin grant.
  - Inputs: req[1:0], last-grant, enable.
  - Output: one-hot gnt.
- Top holds the FSM, the owner register and the steering muxes.

## Test plan
- Single fetch: imem_valid addr 0x100 with mem_ready = 1 → mem_addr = 0x100, mem_cmd = 0, imem_ready = 1 same cycle; mem_r_data 0xDEADBEEF two cycles later → appears on imem_r_data, dmem_r_valid = 0.
- Conflict: both valid (imem 0x0, dmem read 0x200), held → grant order DMEM, IMEM, DMEM, IMEM across four transactions.
- Store: dmem cmd 1 addr 0x400, w_strb 0xF, data 0x12345678, mem_w_ready delayed 3 cycles → mem_w_data = 0x12345678 in WR; return to IDLE on the handshake; no imem grant before that.
- Backpressure: in RD with mem_r_valid = 1 and imem_r_ready = 0 for 4 cycles → mem_r_ready = 0, state remains RD; completes in the cycle imem_r_ready rises.
- Reset mid-read: rst low during RD → all outputs 0 immediately; after release, a new imem request is granted (last grant = IMEM so DMEM wins any simultaneous conflict).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and command encodings for the two-into-one memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } state_t;

   typedef enum logic {
      IMEM = 1'b0,
      DMEM = 1'b1
   } owner_t;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant: on conflict the requester not granted last wins.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,       // bit 0 = imem, bit 1 = dmem
   input  owner_t     last_gnt,
   input  logic       en,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11)
            gnt = (last_gnt == IMEM) ? 2'b10 : 2'b01;
         else
            gnt = req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store requesters with one
// outstanding transaction, round-robin grants and owner-steered responses.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int p_ADDR_BITS = 32,
   parameter int p_DATA_BITS = 32,
   parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [p_ADDR_BITS-1:0] imem_addr,
   input  logic                   imem_cmd,
   input  logic [1:0]             imem_size,
   input  logic                   imem_valid,
   output logic                   imem_ready,
   input  logic                   imem_r_ready,
   output logic                   imem_r_valid,
   output logic [p_DATA_BITS-1:0] imem_r_data,
   output logic                   imem_r_resp,
   input  logic [p_ADDR_BITS-1:0] dmem_addr,
   input  logic                   dmem_cmd,
   input  logic [1:0]             dmem_size,
   input  logic                   dmem_valid,
   output logic                   dmem_ready,
   input  logic                   dmem_r_ready,
   output logic                   dmem_r_valid,
   output logic [p_DATA_BITS-1:0] dmem_r_data,
   output logic                   dmem_r_resp,
   input  logic                   dmem_w_valid,
   input  logic [p_STRB_BITS-1:0] dmem_w_strb,
   input  logic [p_DATA_BITS-1:0] dmem_w_data,
   output logic                   dmem_w_ready,
   output logic                   dmem_w_resp,
   output logic [p_ADDR_BITS-1:0] mem_addr,
   output logic                   mem_cmd,
   output logic [1:0]             mem_size,
   output logic                   mem_valid,
   input  logic                   mem_ready,
   output logic                   mem_r_ready,
   input  logic                   mem_r_valid,
   input  logic [p_DATA_BITS-1:0] mem_r_data,
   input  logic                   mem_r_resp,
   output logic                   mem_w_valid,
   output logic [p_STRB_BITS-1:0] mem_w_strb,
   output logic [p_DATA_BITS-1:0] mem_w_data,
   input  logic                   mem_w_ready,
   input  logic                   mem_w_resp
);

   state_t     state, state_nxt;
   owner_t     owner, owner_nxt;
   owner_t     last_gnt, last_nxt;
   logic [1:0] gnt;

   // Fetches are always reads, so the fetch command bit is never looked at.
   logic unused_imem_cmd;
   assign unused_imem_cmd = imem_cmd;

   mem_arb_rr u_rr (
      .req      ({dmem_valid, imem_valid}),
      .last_gnt (last_gnt),
      .en       (state == IDLE),
      .gnt      (gnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         owner    <= IMEM;
         last_gnt <= IMEM;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last_gnt <= last_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_nxt     = last_gnt;
      mem_valid    = 1'b0;
      mem_addr     = '0;
      mem_cmd      = CMD_RD;
      mem_size     = '0;
      imem_ready   = 1'b0;
      dmem_ready   = 1'b0;
      mem_r_ready  = 1'b0;
      imem_r_valid = 1'b0;
      imem_r_data  = '0;
      imem_r_resp  = 1'b0;
      dmem_r_valid = 1'b0;
      dmem_r_data  = '0;
      dmem_r_resp  = 1'b0;
      mem_w_valid  = 1'b0;
      mem_w_strb   = '0;
      mem_w_data   = '0;
      dmem_w_ready = 1'b0;
      dmem_w_resp  = 1'b0;

      case (state)
         IDLE: begin
            if (gnt[1]) begin
               mem_valid  = 1'b1;
               mem_addr   = dmem_addr;
               mem_cmd    = dmem_cmd;
               mem_size   = dmem_size;
               dmem_ready = mem_ready;
            end else if (gnt[0]) begin
               mem_valid  = 1'b1;
               mem_addr   = imem_addr;
               mem_cmd    = CMD_RD;
               mem_size   = imem_size;
               imem_ready = mem_ready;
            end
            if (mem_valid && mem_ready) begin
               owner_nxt = gnt[1] ? DMEM : IMEM;
               last_nxt  = owner_nxt;
               state_nxt = (mem_cmd == CMD_WR) ? WR : RD;
            end
         end

         RD: begin
            if (owner == IMEM) begin
               mem_r_ready  = imem_r_ready;
               imem_r_valid = mem_r_valid;
               imem_r_data  = mem_r_data;
               imem_r_resp  = mem_r_resp;
            end else begin
               mem_r_ready  = dmem_r_ready;
               dmem_r_valid = mem_r_valid;
               dmem_r_data  = mem_r_data;
               dmem_r_resp  = mem_r_resp;
            end
            if (mem_r_valid && mem_r_ready)
               state_nxt = IDLE;
         end

         WR: begin
            mem_w_valid  = dmem_w_valid;
            mem_w_strb   = dmem_w_strb;
            mem_w_data   = dmem_w_data;
            dmem_w_ready = mem_w_ready;
            dmem_w_resp  = mem_w_resp;
            if (dmem_w_valid && mem_w_ready)
               state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
